eth_tx_scheduler: RTL and testbench

//  Round-robin arbiter and byte sequencer for the shared Ethernet/IPv4/UDP TX path.

---
 rtl/eth_tx_scheduler_if.sv | 34 +++
 rtl/eth_tx_scheduler.sv | 153 +++++++++++++++
 tb/tb_eth_tx_scheduler.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_scheduler_if.sv
// Handshake bundle between the TX scheduler, its payload clients and the framer/MAC byte side.
// master = scheduler, slave = clients/downstream.
interface eth_tx_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 11
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*LEN_W-1:0] req_len;
    logic                     tx_ready;
    logic [NUM_REQ-1:0]       grant;
    logic                     pld_rd;
    logic                     tx_valid;
    logic                     tx_sof;
    logic                     tx_eof;
    logic [2:0]               seg;
    logic [10:0]              byte_idx;
    logic [LEN_W-1:0]         frame_len;
    logic [15:0]              ip_total_len;
    logic [15:0]              udp_len;
    logic                     frame_done;
    logic                     busy;

    modport master (
        input  req, req_len, tx_ready,
        output grant, pld_rd, tx_valid, tx_sof, tx_eof, seg, byte_idx,
               frame_len, ip_total_len, udp_len, frame_done, busy
    );

    modport slave (
        output req, req_len, tx_ready,
        input  grant, pld_rd, tx_valid, tx_sof, tx_eof, seg, byte_idx,
               frame_len, ip_total_len, udp_len, frame_done, busy
    );
endinterface

// File: rtl/eth_tx_scheduler.sv
// Round-robin frame arbiter and Ethernet/IPv4/UDP byte sequencer for the shared TX path.
// Optional: define ETH_MIN_PAD_EN to pad short payloads to 18 bytes.
module eth_tx_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int LEN_W       = 11,
    parameter int MAX_PAYLOAD = 1472,
    parameter int IFG_BYTES   = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    eth_tx_scheduler_if.master bus
);
    localparam int          PTR_W  = $clog2(NUM_REQ);
    localparam int unsigned NREQ_U = NUM_REQ;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PREAMBLE_SFD = 3'd1,
        ETH_HEADER   = 3'd2,
        IP_HEADER    = 3'd3,
        UDP_HEADER   = 3'd4,
        PAYLOAD      = 3'd5,
        FCS          = 3'd6,
        DONE         = 3'd7
    } eth_states_t;

    eth_states_t        state, state_nxt;
    logic [10:0]        byte_idx;
    logic [NUM_REQ-1:0] grant_r;
    logic [PTR_W-1:0]   rr_ptr, gnt_idx, sel_idx, cand_p;
    logic               sel_found;
    logic [LEN_W-1:0]   len_arr [NUM_REQ];
    logic [LEN_W-1:0]   sel_len, sel_sat, frame_len_r;
    logic [15:0]        ip_len_r, udp_len_r, pay_len, seg_len, ifg_cnt;
    logic               tx_valid, adv, seg_last, enter_done, done_r;
    int unsigned        cand;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_len
        assign len_arr[g] = bus.req_len[g*LEN_W +: LEN_W];
    end

    // Search starts at rr_ptr and wraps, so the last owner gets lowest priority.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        cand_p    = '0;
        for (int unsigned k = 0; k < NREQ_U; k++) begin
            cand = 32'(rr_ptr) + k;
            if (cand >= NREQ_U) cand = cand - NREQ_U;
            cand_p = PTR_W'(cand);
            if (!sel_found && bus.req[cand_p]) begin
                sel_found = 1'b1;
                sel_idx   = cand_p;
            end
        end
    end

    assign sel_len = len_arr[sel_idx];
    assign sel_sat = (32'(sel_len) > MAX_PAYLOAD) ? LEN_W'(MAX_PAYLOAD) : sel_len;

`ifdef ETH_MIN_PAD_EN
    assign pay_len = (16'(frame_len_r) < 16'd18) ? 16'd18 : 16'(frame_len_r);
`else
    assign pay_len = 16'(frame_len_r);
`endif

    always_comb begin
        seg_len = 16'd1;
        case (state)
            PREAMBLE_SFD: seg_len = 16'd8;
            ETH_HEADER:   seg_len = 16'd14;
            IP_HEADER:    seg_len = 16'd20;
            UDP_HEADER:   seg_len = 16'd8;
            PAYLOAD:      seg_len = pay_len;
            FCS:          seg_len = 16'd4;
            default:      seg_len = 16'd1;
        endcase
    end

    assign tx_valid   = (state != IDLE) && (state != DONE);
    assign adv        = tx_valid && bus.tx_ready;
    assign seg_last   = (16'(byte_idx) == seg_len - 16'd1);
    assign enter_done = (state == FCS) && adv && seg_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:         if (sel_found) state_nxt = PREAMBLE_SFD;
            PREAMBLE_SFD: if (adv && seg_last) state_nxt = ETH_HEADER;
            ETH_HEADER:   if (adv && seg_last) state_nxt = IP_HEADER;
            IP_HEADER:    if (adv && seg_last) state_nxt = UDP_HEADER;
            UDP_HEADER:   if (adv && seg_last) state_nxt = (pay_len == 16'd0) ? FCS : PAYLOAD;
            PAYLOAD:      if (adv && seg_last) state_nxt = FCS;
            FCS:          if (adv && seg_last) state_nxt = DONE;
            DONE:         if (bus.tx_ready && ifg_cnt == 16'(IFG_BYTES - 1)) state_nxt = IDLE;
            default:      state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx    <= '0;
            ifg_cnt     <= '0;
            grant_r     <= '0;
            gnt_idx     <= '0;
            rr_ptr      <= '0;
            frame_len_r <= '0;
            ip_len_r    <= '0;
            udp_len_r   <= '0;
            done_r      <= 1'b0;
        end else begin
            done_r <= enter_done;

            if (state_nxt != state) byte_idx <= '0;
            else if (adv)           byte_idx <= byte_idx + 11'd1;

            if (state == DONE && bus.tx_ready) ifg_cnt <= ifg_cnt + 16'd1;
            if (state_nxt != DONE)             ifg_cnt <= '0;

            if (state == IDLE && sel_found) begin
                grant_r     <= NUM_REQ'(1) << sel_idx;
                gnt_idx     <= sel_idx;
                frame_len_r <= sel_sat;
                ip_len_r    <= 16'(sel_sat) + 16'd28;
                udp_len_r   <= 16'(sel_sat) + 16'd8;
            end

            if (enter_done) begin
                grant_r <= '0;
                rr_ptr  <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    assign bus.grant        = grant_r;
    assign bus.tx_valid     = tx_valid;
    assign bus.pld_rd       = adv && (state == PAYLOAD) && (16'(byte_idx) < 16'(frame_len_r));
    assign bus.tx_sof       = (state == PREAMBLE_SFD) && (byte_idx == 11'd0);
    assign bus.tx_eof       = (state == FCS) && (byte_idx == 11'd3);
    assign bus.seg          = state;
    assign bus.byte_idx     = byte_idx;
    assign bus.frame_len    = frame_len_r;
    assign bus.ip_total_len = ip_len_r;
    assign bus.udp_len      = udp_len_r;
    assign bus.frame_done   = done_r;
    assign bus.busy         = (state != IDLE);
endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Directed bench for eth_tx_scheduler: reset, round robin, single frame, stall, saturation, padding.
module tb_eth_tx_scheduler;
    localparam int NUM_REQ = 4;
    localparam int LEN_W   = 11;
`ifdef ETH_MIN_PAD_EN
    localparam int PAD_PAY = 18;
`else
    localparam int PAD_PAY = 5;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    eth_tx_scheduler_if #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W)) bus ();

    eth_tx_scheduler #(
        .NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .MAX_PAYLOAD(1472), .IFG_BYTES(12)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_zero(input string p);
        check({p, "_grant"}, 32'(bus.grant), 0);
        check({p, "_pld_rd"}, 32'(bus.pld_rd), 0);
        check({p, "_tx_valid"}, 32'(bus.tx_valid), 0);
        check({p, "_tx_sof"}, 32'(bus.tx_sof), 0);
        check({p, "_tx_eof"}, 32'(bus.tx_eof), 0);
        check({p, "_seg"}, 32'(bus.seg), 0);
        check({p, "_byte_idx"}, 32'(bus.byte_idx), 0);
        check({p, "_frame_len"}, 32'(bus.frame_len), 0);
        check({p, "_ip_len"}, 32'(bus.ip_total_len), 0);
        check({p, "_udp_len"}, 32'(bus.udp_len), 0);
        check({p, "_frame_done"}, 32'(bus.frame_done), 0);
        check({p, "_busy"}, 32'(bus.busy), 0);
    endtask

    task automatic set_len(input int i, input int v);
        bus.req_len[i*LEN_W +: LEN_W] = LEN_W'(v);
    endtask

    task automatic wait_grant();
        int n = 0;
        while (bus.tx_valid !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check("grant_wait_bound", 32'(n < 300), 1);
    endtask

    task automatic run_frame(input int stall_cycles, input logic [3:0] exp_gnt,
                             output int acc, output int npld, output int npay,
                             output int nsof, output int neof);
        int n = 0;
        bit did_stall = 1'b0;
        acc = 0; npld = 0; npay = 0; nsof = 0; neof = 0;
        while (bus.tx_valid === 1'b1 && n < 4000) begin
            if (bus.tx_ready === 1'b1) begin
                acc++;
                if (bus.pld_rd) npld++;
                if (bus.seg == 3'd5) npay++;
                if (bus.tx_sof) nsof++;
                if (bus.tx_eof) neof++;
            end
            @(posedge clk);
            #1;
            if (stall_cycles > 0 && !did_stall && bus.seg == 3'd3 && bus.byte_idx == 11'd7) begin
                did_stall = 1'b1;
                bus.tx_ready = 1'b0;
                for (int s = 0; s < stall_cycles; s++) begin
                    #1;
                    check("stall_seg", 32'(bus.seg), 3);
                    check("stall_byte_idx", 32'(bus.byte_idx), 7);
                    check("stall_grant", 32'(bus.grant), 32'(exp_gnt));
                    check("stall_pld_rd", 32'(bus.pld_rd), 0);
                    @(posedge clk);
                    #1;
                end
                bus.tx_ready = 1'b1;
            end
            #1;
            n++;
        end
        check("frame_end_bound", 32'(n < 4000), 1);
    endtask

    task automatic check_done_entry(input string p);
        check({p, "_frame_done"}, 32'(bus.frame_done), 1);
        check({p, "_done_seg"}, 32'(bus.seg), 7);
        check({p, "_done_grant"}, 32'(bus.grant), 0);
        check({p, "_done_valid"}, 32'(bus.tx_valid), 0);
    endtask

    task automatic count_done(input string p);
        int n = 0;
        while (bus.seg == 3'd7 && n < 100) begin
            n++;
            tick();
            if (n == 1) check({p, "_done_pulse_width"}, 32'(bus.frame_done), 0);
        end
        check({p, "_ifg_cycles"}, 32'(n), 12);
        check({p, "_back_idle"}, 32'(bus.seg), 0);
    endtask

    initial begin
        int acc, npld, npay, nsof, neof;
        logic [3:0] exp_rr [5];
        exp_rr[0] = 4'b0001; exp_rr[1] = 4'b0010; exp_rr[2] = 4'b0100;
        exp_rr[3] = 4'b1000; exp_rr[4] = 4'b0001;

        bus.req = '0;
        bus.req_len = '0;
        bus.tx_ready = 1'b1;
        tick();
        check_zero("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // Round robin, all requesting, zero-length payload
        for (int i = 0; i < 4; i++) set_len(i, 0);
        bus.req = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            wait_grant();
            check("rr_grant", 32'(bus.grant), 32'(exp_rr[f]));
            check("rr_frame_len", 32'(bus.frame_len), 0);
            check("rr_ip_len", 32'(bus.ip_total_len), 28);
            if (f == 4) bus.req = '0;
            run_frame(0, exp_rr[f], acc, npld, npay, nsof, neof);
            check("rr_bytes", 32'(acc), 54);
            check("rr_pld_rd", 32'(npld), 0);
            check("rr_payload_cycles", 32'(npay), 0);
            check("rr_sof", 32'(nsof), 1);
            check("rr_eof", 32'(neof), 1);
            check_done_entry("rr");
        end
        count_done("rr");

        // Single frame, 64 bytes from source 1
        set_len(1, 64);
        bus.req = 4'b0010;
        wait_grant();
        bus.req = '0;
        check("single_grant", 32'(bus.grant), 2);
        check("single_frame_len", 32'(bus.frame_len), 64);
        check("single_ip_len", 32'(bus.ip_total_len), 92);
        check("single_udp_len", 32'(bus.udp_len), 72);
        check("single_busy", 32'(bus.busy), 1);
        run_frame(0, 4'b0010, acc, npld, npay, nsof, neof);
        check("single_bytes", 32'(acc), 118);
        check("single_pld_rd", 32'(npld), 64);
        check("single_payload_cycles", 32'(npay), 64);
        check_done_entry("single");
        count_done("single");

        // Stall at IP_HEADER byte 7 for 5 cycles
        set_len(2, 10);
        bus.req = 4'b0100;
        wait_grant();
        bus.req = '0;
        check("stall_grant_start", 32'(bus.grant), 4);
        run_frame(5, 4'b0100, acc, npld, npay, nsof, neof);
        check("stall_bytes", 32'(acc), 64);
        check("stall_frame_pld_rd", 32'(npld), 10);
        check_done_entry("stall");
        count_done("stall");

        // Length saturation
        set_len(3, 2000);
        bus.req = 4'b1000;
        wait_grant();
        bus.req = '0;
        check("sat_grant", 32'(bus.grant), 8);
        check("sat_frame_len", 32'(bus.frame_len), 1472);
        check("sat_ip_len", 32'(bus.ip_total_len), 1500);
        check("sat_udp_len", 32'(bus.udp_len), 1480);
        run_frame(0, 4'b1000, acc, npld, npay, nsof, neof);
        check("sat_bytes", 32'(acc), 1526);
        check("sat_pld_rd", 32'(npld), 1472);
        check_done_entry("sat");
        count_done("sat");

        // Short payload, padded only when the pad option is built in
        set_len(0, 5);
        bus.req = 4'b0001;
        wait_grant();
        bus.req = '0;
        check("pad_grant", 32'(bus.grant), 1);
        check("pad_ip_len", 32'(bus.ip_total_len), 33);
        check("pad_udp_len", 32'(bus.udp_len), 13);
        run_frame(0, 4'b0001, acc, npld, npay, nsof, neof);
        check("pad_payload_cycles", 32'(npay), 32'(PAD_PAY));
        check("pad_pld_rd", 32'(npld), 5);
        check("pad_bytes", 32'(acc), 32'(54 + PAD_PAY));
        check_done_entry("pad");
        count_done("pad");

        // Reset in the middle of PAYLOAD
        set_len(2, 64);
        bus.req = 4'b0100;
        wait_grant();
        bus.req = '0;
        begin
            int n = 0;
            while (!(bus.seg == 3'd5 && bus.byte_idx == 11'd3) && n < 500) begin
                tick();
                n++;
            end
            check("midreset_reach_payload", 32'(n < 500), 1);
        end
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_len(i, 0);
        bus.req = 4'b1111;
        wait_grant();
        bus.req = '0;
        check("post_reset_grant", 32'(bus.grant), 1);
        run_frame(0, 4'b0001, acc, npld, npay, nsof, neof);
        check("post_reset_bytes", 32'(acc), 54);
        count_done("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
